// File: rtl/AXI_package.sv
// Shared register width and coprocessor wrapper command/status encodings.
package AXI_package;

    localparam int REG_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0] CMD_NOP                = 'd0;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 'd1;
    localparam logic [REG_WIDTH-1:0] CMD_START              = 'd2;
    localparam logic [REG_WIDTH-1:0] CMD_RESET              = 'd3;
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 'd4;
    localparam logic [REG_WIDTH-1:0] CMD_RESTART            = 'd5;

    localparam logic [REG_WIDTH-1:0] STATUS_IDLE     = 'd0;
    localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 'd1;
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 'd2;
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 'd3;
    localparam logic [REG_WIDTH-1:0] STATUS_ERROR    = 'd4;

endpackage

// File: rtl/regex_cmd_driver.sv
// Job-level driver for the regex coprocessor wrapper: loads a program,
// starts the run, waits for a verdict (with timeout), reads the elapsed
// clock, restarts the wrapper and hands back a result. All outputs are
// registered; the combinational process computes next-cycle values.
module regex_cmd_driver
    import AXI_package::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2**20,
    parameter int unsigned LD_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic                 job_load,
    input  logic [REG_WIDTH-1:0] job_base_addr,
    input  logic [REG_WIDTH-1:0] job_start_cc,
    input  logic [REG_WIDTH-1:0] job_end_cc,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [LD_WIDTH-1:0]  ld_data,
    input  logic                 ld_last,
    output logic [REG_WIDTH-1:0] cmd_register,
    output logic [REG_WIDTH-1:0] address_register,
    output logic [REG_WIDTH-1:0] data_in_register,
    output logic [REG_WIDTH-1:0] start_cc_pointer_register,
    output logic [REG_WIDTH-1:0] end_cc_pointer_register,
    input  logic [REG_WIDTH-1:0] status_register,
    input  logic [REG_WIDTH-1:0] data_o_register,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_code,
    output logic [REG_WIDTH-1:0] res_elapsed
);

    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_LOAD, ST_START, ST_WAIT,
        ST_READCC, ST_RESTART, ST_ABORT, ST_RESULT
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_nx;
    logic [REG_WIDTH-1:0] base_q, base_nx;
    logic [REG_WIDTH-1:0] idx_q, idx_nx;
    logic [31:0]          timer_q, timer_nx;

    logic [REG_WIDTH-1:0] cmd_nx, addr_nx, data_nx, scc_nx, ecc_nx, elapsed_nx;
    logic                 job_ready_nx, ld_ready_nx, res_valid_nx;
    logic [1:0]           code_nx;
    logic                 timeout;

    // State, bookkeeping and all output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q                   <= ST_INIT;
            base_q                    <= '0;
            idx_q                     <= '0;
            timer_q                   <= '0;
            cmd_register              <= CMD_NOP;
            address_register          <= '0;
            data_in_register          <= '0;
            start_cc_pointer_register <= '0;
            end_cc_pointer_register   <= '0;
            job_ready                 <= 1'b0;
            ld_ready                  <= 1'b0;
            res_valid                 <= 1'b0;
            res_code                  <= '0;
            res_elapsed               <= '0;
        end else begin
            state_q                   <= state_nx;
            base_q                    <= base_nx;
            idx_q                     <= idx_nx;
            timer_q                   <= timer_nx;
            cmd_register              <= cmd_nx;
            address_register          <= addr_nx;
            data_in_register          <= data_nx;
            start_cc_pointer_register <= scc_nx;
            end_cc_pointer_register   <= ecc_nx;
            job_ready                 <= job_ready_nx;
            ld_ready                  <= ld_ready_nx;
            res_valid                 <= res_valid_nx;
            res_code                  <= code_nx;
            res_elapsed               <= elapsed_nx;
        end
    end

    // Next-state and next-output logic; cmd_nx is what the wrapper sees next cycle.
    always_comb begin
        state_nx     = state_q;
        base_nx      = base_q;
        idx_nx       = idx_q;
        timer_nx     = timer_q;
        cmd_nx       = CMD_NOP;
        addr_nx      = address_register;
        data_nx      = data_in_register;
        scc_nx       = start_cc_pointer_register;
        ecc_nx       = end_cc_pointer_register;
        job_ready_nx = 1'b0;
        ld_ready_nx  = 1'b0;
        res_valid_nx = 1'b0;
        code_nx      = res_code;
        elapsed_nx   = res_elapsed;
        timeout      = (timer_q == TIMEOUT_LAST);

        case (state_q)
            ST_INIT: begin
                cmd_nx   = CMD_RESET;
                state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (job_valid && job_ready) begin
                    base_nx = job_base_addr;
                    addr_nx = job_base_addr;
                    scc_nx  = job_start_cc;
                    ecc_nx  = job_end_cc;
                    idx_nx  = '0;
                    if (job_load) begin
                        state_nx    = ST_LOAD;
                        ld_ready_nx = 1'b1;
                    end else begin
                        state_nx = ST_START;
                        cmd_nx   = CMD_START;
                        timer_nx = '0;
                    end
                end else begin
                    job_ready_nx = (status_register == STATUS_IDLE);
                end
            end
            ST_LOAD: begin
                ld_ready_nx = 1'b1;
                if (ld_valid && ld_ready) begin
                    cmd_nx  = CMD_WRITE;
                    addr_nx = base_q + idx_q;
                    data_nx = REG_WIDTH'(ld_data);
                    idx_nx  = idx_q + 1'b1;
                    if (ld_last) begin
                        // The final write occupies the next cycle; START follows it.
                        ld_ready_nx = 1'b0;
                        state_nx    = ST_START;
                        timer_nx    = '0;
                    end
                end
            end
            ST_START, ST_WAIT: begin
                timer_nx = timer_q + 32'd1;
                if (timeout) begin
                    code_nx    = 2'd3;
                    elapsed_nx = REG_WIDTH'(timer_q + 32'd1);
                    cmd_nx     = CMD_RESET;
                    state_nx   = ST_ABORT;
                end else if (state_q == ST_START) begin
                    if (status_register == STATUS_RUNNING) begin
                        state_nx = ST_WAIT;
                    end else begin
                        cmd_nx = CMD_START;
                    end
                end else if (status_register == STATUS_ACCEPTED) begin
                    code_nx  = 2'd0;
                    cmd_nx   = CMD_READ_ELAPSED_CLOCK;
                    state_nx = ST_READCC;
                end else if (status_register == STATUS_REJECTED) begin
                    code_nx  = 2'd1;
                    cmd_nx   = CMD_READ_ELAPSED_CLOCK;
                    state_nx = ST_READCC;
                end else if (status_register == STATUS_ERROR) begin
                    code_nx  = 2'd2;
                    cmd_nx   = CMD_READ_ELAPSED_CLOCK;
                    state_nx = ST_READCC;
                end else if (status_register == STATUS_IDLE) begin
                    code_nx    = 2'd2;
                    elapsed_nx = '0;
                    cmd_nx     = CMD_RESTART;
                    state_nx   = ST_RESTART;
                end
            end
            ST_READCC: begin
                elapsed_nx = data_o_register;
                cmd_nx     = CMD_RESTART;
                state_nx   = ST_RESTART;
            end
            ST_RESTART: begin
                if (status_register == STATUS_IDLE) begin
                    res_valid_nx = 1'b1;
                    state_nx     = ST_RESULT;
                end else begin
                    cmd_nx = CMD_RESTART;
                end
            end
            ST_ABORT: begin
                res_valid_nx = 1'b1;
                state_nx     = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_valid && res_ready) begin
                    job_ready_nx = (status_register == STATUS_IDLE);
                    state_nx     = ST_IDLE;
                end else begin
                    res_valid_nx = 1'b1;
                end
            end
            default: state_nx = ST_INIT;
        endcase
    end

endmodule

// File: tb/tb_regex_cmd_driver.sv
// Directed bench for regex_cmd_driver: a main instance driven by a small
// wrapper model, plus a second instance with a short timeout whose wrapper
// sticks in RUNNING.
module tb_regex_cmd_driver;
    import AXI_package::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- main instance signals ----------------
    logic                 job_valid, job_ready, job_load;
    logic [REG_WIDTH-1:0] job_base_addr, job_start_cc, job_end_cc;
    logic                 ld_valid, ld_ready, ld_last;
    logic [31:0]          ld_data;
    logic [REG_WIDTH-1:0] cmd_register, address_register, data_in_register;
    logic [REG_WIDTH-1:0] start_cc_pointer_register, end_cc_pointer_register;
    logic [REG_WIDTH-1:0] status_register = STATUS_IDLE;
    logic [REG_WIDTH-1:0] data_o_register;
    logic                 res_valid, res_ready;
    logic [1:0]           res_code;
    logic [REG_WIDTH-1:0] res_elapsed;

    // ---------------- timeout instance signals ----------------
    logic                 t_job_valid, t_job_ready;
    logic                 t_ld_ready;
    logic [REG_WIDTH-1:0] t_cmd, t_addr, t_data, t_scc, t_ecc;
    logic [REG_WIDTH-1:0] t_status = STATUS_IDLE;
    logic                 t_res_valid, t_res_ready;
    logic [1:0]           t_res_code;
    logic [REG_WIDTH-1:0] t_res_elapsed;

    regex_cmd_driver #(.TIMEOUT_CYCLES(4096), .LD_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_load(job_load),
        .job_base_addr(job_base_addr), .job_start_cc(job_start_cc), .job_end_cc(job_end_cc),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .cmd_register(cmd_register), .address_register(address_register),
        .data_in_register(data_in_register),
        .start_cc_pointer_register(start_cc_pointer_register),
        .end_cc_pointer_register(end_cc_pointer_register),
        .status_register(status_register), .data_o_register(data_o_register),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_code(res_code), .res_elapsed(res_elapsed)
    );

    regex_cmd_driver #(.TIMEOUT_CYCLES(16), .LD_WIDTH(32)) dut16 (
        .clk(clk), .rst(rst),
        .job_valid(t_job_valid), .job_ready(t_job_ready), .job_load(1'b0),
        .job_base_addr(32'h0), .job_start_cc(32'h1), .job_end_cc(32'h2),
        .ld_valid(1'b0), .ld_ready(t_ld_ready), .ld_data(32'h0), .ld_last(1'b0),
        .cmd_register(t_cmd), .address_register(t_addr),
        .data_in_register(t_data),
        .start_cc_pointer_register(t_scc),
        .end_cc_pointer_register(t_ecc),
        .status_register(t_status), .data_o_register(32'h0),
        .res_valid(t_res_valid), .res_ready(t_res_ready),
        .res_code(t_res_code), .res_elapsed(t_res_elapsed)
    );

    // ---------------- main wrapper model ----------------
    // RUNNING a couple of cycles after START, a terminal status after ~50,
    // IDLE one cycle after RESTART or RESET is seen.
    logic [REG_WIDTH-1:0] term_st     = STATUS_ACCEPTED;
    logic [REG_WIDTH-1:0] elapsed_val = 32'd50;
    int m_cnt = 0;

    assign data_o_register = (cmd_register == CMD_READ_ELAPSED_CLOCK) ? elapsed_val : '0;

    always @(posedge clk) begin
        if (cmd_register == CMD_RESET) begin
            status_register <= STATUS_IDLE;
            m_cnt <= 0;
        end else if (m_cnt == 0 && status_register == STATUS_IDLE && cmd_register == CMD_START) begin
            m_cnt <= 1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 2) status_register <= STATUS_RUNNING;
            if (m_cnt == 50) begin
                status_register <= term_st;
                m_cnt <= 0;
            end
        end else if (cmd_register == CMD_RESTART) begin
            status_register <= STATUS_IDLE;
        end
    end

    // Timeout-instance wrapper: RUNNING forever once started, IDLE on RESET.
    always @(posedge clk) begin
        if (t_cmd == CMD_RESET) t_status <= STATUS_IDLE;
        else if (t_cmd == CMD_START) t_status <= STATUS_RUNNING;
    end

    // Command / result event counters, sampled mid-cycle.
    int n_reset = 0, n_restart = 0, n_readcc = 0, n_write = 0, n_rv = 0, t_n_reset = 0;
    always @(negedge clk) begin
        if (cmd_register == CMD_RESET)              n_reset++;
        if (cmd_register == CMD_RESTART)            n_restart++;
        if (cmd_register == CMD_READ_ELAPSED_CLOCK) n_readcc++;
        if (cmd_register == CMD_WRITE)              n_write++;
        if (res_valid)                              n_rv++;
        if (t_cmd == CMD_RESET)                     t_n_reset++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, b2, b3;
        bit seen;

        rst = 1'b0;
        job_valid = 0; job_load = 0; job_base_addr = '0; job_start_cc = '0; job_end_cc = '0;
        ld_valid = 0; ld_data = '0; ld_last = 0; res_ready = 0;
        t_job_valid = 0; t_res_ready = 0;
        repeat (3) tick();

        // ---- reset values ----
        check("rst_cmd", cmd_register, CMD_NOP);
        check("rst_job_ready", job_ready, 0);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_code", res_code, 0);
        check("rst_res_elapsed", res_elapsed, 0);
        check("rst_addr", address_register, 0);
        check("rst_t_cmd", t_cmd, CMD_NOP);

        // ---- reset release: one CMD_RESET cycle then NOP ----
        b0 = n_reset;
        rst = 1'b1;
        tick();
        check("init_cmd_reset", cmd_register, CMD_RESET);
        tick();
        check("init_cmd_nop", cmd_register, CMD_NOP);
        check("init_job_ready", job_ready, 1);
        repeat (3) tick();
        check("init_reset_cycles", n_reset - b0, 1);

        // ---- load job: base 0x10, words A, B, gap, C(last) ----
        job_valid = 1; job_load = 1; job_base_addr = 32'h10;
        job_start_cc = 32'h100; job_end_cc = 32'h200;
        tick();
        job_valid = 0;
        check("ld_job_ready_low", job_ready, 0);
        check("ld_ready_high", ld_ready, 1);
        check("ld_cmd_nop", cmd_register, CMD_NOP);
        check("ld_start_cc", start_cc_pointer_register, 32'h100);
        check("ld_end_cc", end_cc_pointer_register, 32'h200);
        ld_valid = 1; ld_data = 32'hA;
        tick();
        check("w0_cmd", cmd_register, CMD_WRITE);
        check("w0_addr", address_register, 32'h10);
        check("w0_data", data_in_register, 32'hA);
        ld_data = 32'hB;
        tick();
        check("w1_cmd", cmd_register, CMD_WRITE);
        check("w1_addr", address_register, 32'h11);
        check("w1_data", data_in_register, 32'hB);
        ld_valid = 0;
        tick();
        check("gap_cmd", cmd_register, CMD_NOP);
        ld_valid = 1; ld_data = 32'hC; ld_last = 1;
        tick();
        check("w2_cmd", cmd_register, CMD_WRITE);
        check("w2_addr", address_register, 32'h12);
        check("w2_data", data_in_register, 32'hC);
        check("w2_ld_ready_low", ld_ready, 0);
        ld_valid = 0; ld_last = 0;
        b1 = n_restart; b2 = n_readcc;
        tick();
        check("start_cmd", cmd_register, CMD_START);

        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            seen = res_valid;
        end
        check("acc_res_valid", seen, 1);
        check("acc_res_code", res_code, 0);
        check("acc_res_elapsed", res_elapsed, 50);
        check("acc_readcc_cycles", n_readcc - b2, 1);
        // Model sees RESTART one cycle late, so RESTART is held for two cycles.
        check("acc_restart_cycles", n_restart - b1, 2);
        check("acc_start_cc_held", start_cc_pointer_register, 32'h100);
        res_ready = 1;
        tick();
        res_ready = 0;
        check("acc_res_valid_low", res_valid, 0);
        check("acc_job_ready_b2b", job_ready, 1);

        // ---- no-load job ending in ERROR, result held under backpressure ----
        term_st = STATUS_ERROR; elapsed_val = 32'd7;
        b0 = n_write;
        job_valid = 1; job_load = 0; job_base_addr = 32'h40; job_start_cc = 32'h3; job_end_cc = 32'h4;
        tick();
        job_valid = 0;
        check("err_cmd_start", cmd_register, CMD_START);
        check("err_ld_ready", ld_ready, 0);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            seen = res_valid;
        end
        check("err_res_valid", seen, 1);
        check("err_res_code", res_code, 2);
        check("err_res_elapsed", res_elapsed, 7);
        check("err_no_writes", n_write - b0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_res_valid", res_valid, 1);
            check("hold_res_code", res_code, 2);
            check("hold_res_elapsed", res_elapsed, 7);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        check("err_res_valid_low", res_valid, 0);
        tick();

        // ---- reset pulse during LOAD ----
        job_valid = 1; job_load = 1; job_base_addr = 32'h80; job_start_cc = 32'h9; job_end_cc = 32'hA;
        tick();
        job_valid = 0;
        ld_valid = 1; ld_data = 32'h55;
        tick();
        check("rl_write_cmd", cmd_register, CMD_WRITE);
        check("rl_write_addr", address_register, 32'h80);
        ld_valid = 0;
        #2;
        rst = 1'b0;
        #1;
        check("rl_async_cmd", cmd_register, CMD_NOP);
        check("rl_async_addr", address_register, 0);
        check("rl_async_data", data_in_register, 0);
        check("rl_async_scc", start_cc_pointer_register, 0);
        check("rl_async_ecc", end_cc_pointer_register, 0);
        check("rl_async_ld_ready", ld_ready, 0);
        check("rl_async_job_ready", job_ready, 0);
        tick();
        b0 = n_reset; b3 = n_rv;
        rst = 1'b1;
        tick();
        check("rl_init_reset", cmd_register, CMD_RESET);
        tick();
        check("rl_init_nop", cmd_register, CMD_NOP);
        repeat (20) tick();
        check("rl_reset_cycles", n_reset - b0, 1);
        check("rl_no_result", n_rv - b3, 0);
        check("rl_job_ready", job_ready, 1);

        // ---- timeout instance: stuck RUNNING ----
        check("to_job_ready", t_job_ready, 1);
        t_job_valid = 1;
        tick();
        t_job_valid = 0;
        b0 = t_n_reset;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            seen = t_res_valid;
        end
        check("to_res_valid", seen, 1);
        check("to_res_code", t_res_code, 3);
        check("to_res_elapsed", t_res_elapsed, 16);
        check("to_reset_cycles", t_n_reset - b0, 1);
        t_res_ready = 1;
        tick();
        t_res_ready = 0;
        check("to_res_valid_low", t_res_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
